vend_sequencer: RTL and testbench

Transaction controller for the vending datapath. It accepts validated coin events one at a time and accumulates credit against a fixed price. It sequences the product dispenser through a request/ack handshake, then pays back change or a refund coin by coin through the coin ejector. It sits between the coin-sensor front end, the product dispenser and the coin ejector, and uses a 1 s strobe from the existing clock divider for its inactivity timeout.

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_sequencer_if.sv | 26 ++
 rtl/vend_sequencer_change_picker.sv | 20 ++
 rtl/vend_sequencer.sv | 139 +++++++++++++
 tb/tb_vend_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller: FSM encoding,
// coin denominations and the coin legality check.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [3:0] COIN_1  = 4'd1;
  localparam logic [3:0] COIN_5  = 4'd5;
  localparam logic [3:0] COIN_10 = 4'd10;

  function automatic logic coin_legal(input logic [3:0] val);
    return (val == COIN_1) || (val == COIN_5) || (val == COIN_10);
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the coin front end,
// product dispenser and coin ejector (slave).
interface vend_sequencer_if;

  logic       coin_valid;
  logic [3:0] coin_val;
  logic       coin_ready;
  logic       coin_rej;
  logic       cancel;
  logic       vend_req;
  logic       vend_ack;
  logic       chg_req;
  logic [3:0] chg_coin;
  logic       chg_ack;

  modport master (
    input  coin_valid, coin_val, cancel, vend_ack, chg_ack,
    output coin_ready, coin_rej, vend_req, chg_req, chg_coin
  );

  modport slave (
    output coin_valid, coin_val, cancel, vend_ack, chg_ack,
    input  coin_ready, coin_rej, vend_req, chg_req, chg_coin
  );

endinterface

// File: rtl/vend_sequencer_change_picker.sv
// Greedy payout denomination: the largest coin that does not exceed credit.
module change_picker
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [3:0]          coin
);

  always_comb begin
    coin = COIN_1;
    if (credit >= CREDIT_W'(COIN_10)) begin
      coin = COIN_10;
    end else if (credit >= CREDIT_W'(COIN_5)) begin
      coin = COIN_5;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit collection, dispense handshake and
// coin-by-coin change/refund payout. Define SALES_CNT_EN to add sales_cnt.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE     = 20,
  parameter int CREDIT_W  = 6,
  parameter int TIMEOUT_S = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_1s,
  vend_sequencer_if.master    bus,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state_o
`ifdef SALES_CNT_EN
  ,
  output logic [15:0]         sales_cnt
`endif
);

  localparam int                  TMO_W     = $clog2(TIMEOUT_S + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [TMO_W-1:0]    TMO_LIMIT = TMO_W'(TIMEOUT_S);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                coin_rej_q, coin_rej_d;
`ifdef SALES_CNT_EN
  logic [15:0]         sales_cnt_q, sales_cnt_d;
`endif

  logic                coin_take;
  logic                coin_ok;
  logic [CREDIT_W-1:0] credit_add;
  logic [CREDIT_W-1:0] chg_rem;
  logic [TMO_W-1:0]    tmo_inc;
  logic [3:0]          pick_coin;

  change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
    .credit (credit_q),
    .coin   (pick_coin)
  );

  assign bus.coin_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign coin_take      = bus.coin_valid && bus.coin_ready;
  assign coin_ok        = coin_legal(bus.coin_val);
  assign credit_add     = credit_q + CREDIT_W'(bus.coin_val);
  assign chg_rem        = credit_q - CREDIT_W'(pick_coin);
  assign tmo_inc        = tmo_q + TMO_W'(1);

  assign bus.vend_req = (state_q == VEND);
  assign bus.chg_req  = (state_q == CHANGE) && (credit_q != '0);
  assign bus.chg_coin = (state_q == CHANGE) ? pick_coin : 4'd0;
  assign bus.coin_rej = coin_rej_q;
  assign credit       = credit_q;
  assign state_o      = state_q;
`ifdef SALES_CNT_EN
  assign sales_cnt    = sales_cnt_q;
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    tmo_d      = tmo_q;
    coin_rej_d = 1'b0;
`ifdef SALES_CNT_EN
    sales_cnt_d = sales_cnt_q;
`endif
    case (state_q)
      IDLE, COLLECT: begin
        // An accepted coin, legal or not, pre-empts cancel and the timeout tick.
        if (coin_take) begin
          if (coin_ok) begin
            credit_d = credit_add;
            tmo_d    = '0;
            state_d  = (credit_add >= PRICE_C) ? VEND : COLLECT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end else if (state_q == COLLECT) begin
          if (bus.cancel) begin
            tmo_d   = '0;
            state_d = CHANGE;
          end else if (tick_1s) begin
            if (tmo_inc == TMO_LIMIT) begin
              tmo_d   = '0;
              state_d = CHANGE;
            end else begin
              tmo_d = tmo_inc;
            end
          end
        end
      end
      VEND: begin
        if (bus.vend_ack) begin
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_q != PRICE_C) ? CHANGE : IDLE;
`ifdef SALES_CNT_EN
          sales_cnt_d = sales_cnt_q + 16'd1;
`endif
        end
      end
      CHANGE: begin
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (bus.chg_ack) begin
          credit_d = chg_rem;
          if (chg_rem == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      tmo_q      <= '0;
      coin_rej_q <= 1'b0;
`ifdef SALES_CNT_EN
      sales_cnt_q <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      tmo_q      <= tmo_d;
      coin_rej_q <= coin_rej_d;
`ifdef SALES_CNT_EN
      sales_cnt_q <= sales_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (PRICE=20, TIMEOUT_S=30),
// covering sale, change, cancel refund, timeout, illegal coin and reset.
module tb_vend_sequencer;

  localparam int ST_IDLE    = 0;
  localparam int ST_COLLECT = 1;
  localparam int ST_VEND    = 2;
  localparam int ST_CHANGE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1s = 1'b0;
  logic [5:0] credit;
  logic [1:0] state_o;
`ifdef SALES_CNT_EN
  logic [15:0] sales_cnt;
`endif

  int total = 0;
  int bad   = 0;

  vend_sequencer_if bus ();

  vend_sequencer #(.PRICE(20), .CREDIT_W(6), .TIMEOUT_S(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1s   (tick_1s),
    .bus       (bus.master),
    .credit    (credit),
    .state_o   (state_o)
`ifdef SALES_CNT_EN
    ,
    .sales_cnt (sales_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then return all strobes low.
  task automatic applyStimulus(input logic cv, input logic [3:0] val, input logic can,
                               input logic tk, input logic va, input logic ca);
    bus.coin_valid = cv;
    bus.coin_val   = val;
    bus.cancel     = can;
    tick_1s        = tk;
    bus.vend_ack   = va;
    bus.chg_ack    = ca;
    @(posedge clk);
    #1;
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
    bus.cancel     = 1'b0;
    tick_1s        = 1'b0;
    bus.vend_ack   = 1'b0;
    bus.chg_ack    = 1'b0;
  endtask

  task automatic applyCoin(input logic [3:0] val);
    applyStimulus(1'b1, val, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_val   = 4'd0;
    bus.cancel     = 1'b0;
    bus.vend_ack   = 1'b0;
    bus.chg_ack    = 1'b0;

    rst = 1'b0;
    applyIdle();
    applyIdle();
    checkOutput("rst_state", state_o, ST_IDLE);
    checkOutput("rst_credit", credit, 0);
    checkOutput("rst_vend_req", bus.vend_req, 0);
    checkOutput("rst_chg_req", bus.chg_req, 0);
    checkOutput("rst_chg_coin", bus.chg_coin, 0);
    checkOutput("rst_coin_rej", bus.coin_rej, 0);
`ifdef SALES_CNT_EN
    checkOutput("rst_sales", sales_cnt, 0);
`endif
    rst = 1'b1;
    applyIdle();
    checkOutput("idle_ready", bus.coin_ready, 1);

    $display("[TB] exact price sale");
    applyCoin(4'd10);
    checkOutput("s1_state_c1", state_o, ST_COLLECT);
    checkOutput("s1_credit_c1", credit, 10);
    applyCoin(4'd10);
    checkOutput("s1_state_vend", state_o, ST_VEND);
    checkOutput("s1_credit_vend", credit, 20);
    checkOutput("s1_vend_req", bus.vend_req, 1);
    checkOutput("s1_ready_vend", bus.coin_ready, 0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("s1_vend_hold", state_o, ST_VEND);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("s1_state_done", state_o, ST_IDLE);
    checkOutput("s1_credit_done", credit, 0);
    checkOutput("s1_vend_req_off", bus.vend_req, 0);
    checkOutput("s1_chg_req", bus.chg_req, 0);
`ifdef SALES_CNT_EN
    checkOutput("s1_sales", sales_cnt, 1);
`endif

    $display("[TB] sale with change");
    applyCoin(4'd10);
    applyCoin(4'd5);
    checkOutput("s2_credit_15", credit, 15);
    applyCoin(4'd10);
    checkOutput("s2_state_vend", state_o, ST_VEND);
    checkOutput("s2_credit_25", credit, 25);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("s2_state_chg", state_o, ST_CHANGE);
    checkOutput("s2_credit_5", credit, 5);
    checkOutput("s2_chg_req", bus.chg_req, 1);
    checkOutput("s2_chg_coin", bus.chg_coin, 5);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s2_state_idle", state_o, ST_IDLE);
    checkOutput("s2_credit_0", credit, 0);
    checkOutput("s2_chg_req_off", bus.chg_req, 0);
`ifdef SALES_CNT_EN
    checkOutput("s2_sales", sales_cnt, 2);
`endif

    $display("[TB] cancel refund");
    applyCoin(4'd5);
    applyCoin(4'd1);
    applyCoin(4'd1);
    checkOutput("s3_credit_7", credit, 7);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_state_chg", state_o, ST_CHANGE);
    checkOutput("s3_credit_kept", credit, 7);
    checkOutput("s3_ready_chg", bus.coin_ready, 0);
    checkOutput("s3_coin_a", bus.chg_coin, 5);
    applyCoin(4'd10);
    checkOutput("s3_coin_ignored", credit, 7);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s3_credit_2", credit, 2);
    checkOutput("s3_coin_b", bus.chg_coin, 1);
    checkOutput("s3_ready_chg2", bus.coin_ready, 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s3_credit_1", credit, 1);
    checkOutput("s3_coin_c", bus.chg_coin, 1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s3_state_idle", state_o, ST_IDLE);
    checkOutput("s3_credit_0", credit, 0);

    $display("[TB] inactivity timeout");
    applyCoin(4'd5);
    for (int i = 0; i < 28; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyIdle();
    end
    checkOutput("s4_after28", state_o, ST_COLLECT);
    applyStimulus(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_coin_tick", credit, 6);
    for (int i = 0; i < 29; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyIdle();
    end
    checkOutput("s4_after29", state_o, ST_COLLECT);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s4_timeout", state_o, ST_CHANGE);
    checkOutput("s4_refund_credit", credit, 6);
    checkOutput("s4_coin_a", bus.chg_coin, 5);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s4_coin_b", bus.chg_coin, 1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s4_state_idle", state_o, ST_IDLE);

    $display("[TB] illegal coin");
    applyCoin(4'd1);
    applyCoin(4'd3);
    checkOutput("s5_rej_hi", bus.coin_rej, 1);
    checkOutput("s5_credit", credit, 1);
    checkOutput("s5_state", state_o, ST_COLLECT);
    applyIdle();
    checkOutput("s5_rej_lo", bus.coin_rej, 0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s5_coin_1", bus.chg_coin, 1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s5_state_idle", state_o, ST_IDLE);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("s5_stray_ack", state_o, ST_IDLE);

    $display("[TB] reset during vend");
    applyCoin(4'd10);
    applyCoin(4'd10);
    checkOutput("s6_vend_req", bus.vend_req, 1);
    rst = 1'b0;
    applyIdle();
    rst = 1'b1;
    checkOutput("s6_state", state_o, ST_IDLE);
    checkOutput("s6_credit", credit, 0);
    checkOutput("s6_vend_req_off", bus.vend_req, 0);
`ifdef SALES_CNT_EN
    checkOutput("s6_sales_rst", sales_cnt, 0);
`endif
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("s6_late_ack_state", state_o, ST_IDLE);
    checkOutput("s6_late_ack_credit", credit, 0);
`ifdef SALES_CNT_EN
    checkOutput("s6_late_ack_sales", sales_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
